// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types, RAM handshake states and arbiter FSM encoding.
package cpu_types_pkg;
    localparam int ARB_NREQ = 2;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} arb_state_t;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational 2-way round-robin chooser; masked requesters never win,
// and a tie goes to the requester that was not served last.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic [1:0] excl,
    output logic       valid,
    output logic       winner
);
    logic [1:0] r;
    always_comb begin
        r      = req & ~excl;
        valid  = |r;
        winner = &r ? ~last : r[1];
    end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of one RAM port between two cores, one transaction in flight.
// Define ARB_STATS_EN to add the grants0/grants1/conflicts counters.
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NREQ       = ARB_NREQ,
    parameter bit RESET_PRIO = 1'b0
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic [1:0] dREN,
    input  logic [1:0] dWEN,
    input  word_t     daddr0,
    input  word_t     daddr1,
    input  word_t     dstore0,
    input  word_t     dstore1,
    output word_t     dload,
    output logic [1:0] dwait,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
`ifdef ARB_STATS_EN
    ,
    output logic [31:0] grants0,
    output logic [31:0] grants1,
    output logic [31:0] conflicts
`endif
);
    arb_state_t      state, next_state;
    logic [NREQ-1:0] req;
    logic [1:0]      excl;
    logic            last, cur, granted, ack, pick_valid, pick_winner;

    assign req     = dREN | dWEN;
    assign granted = state != IDLE;
    assign cur     = state == GRANT1;
    assign ack     = granted & req[cur] & (ramstate == ACCESS || ramstate == ERROR);
    // While granted, the current owner is masked so one chooser serves both handoff and abort.
    assign excl    = granted ? (cur ? 2'b10 : 2'b01) : 2'b00;

    rr_pick2 u_pick (
        .req    (req),
        .last   (last),
        .excl   (excl),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            last  <= ~RESET_PRIO;
        end else begin
            state <= next_state;
            if (ack) last <= cur;
        end
    end

    always_comb
        next_state = (granted && req[cur] && !ack) ? state :
                     !pick_valid ? IDLE :
                     pick_winner ? GRANT1 : GRANT0;

    always_comb begin
        ramREN   = granted & dREN[cur];
        ramWEN   = granted & dWEN[cur];
        ramaddr  = !granted ? '0 : cur ? daddr1 : daddr0;
        ramstore = !granted ? '0 : cur ? dstore1 : dstore0;
        dwait    = ~{ack & cur, ack & ~cur};
        dload    = ramload;
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            grants0   <= '0;
            grants1   <= '0;
            conflicts <= '0;
        end else begin
            if (ack && !cur) grants0 <= grants0 + 32'd1;
            if (ack && cur) grants1 <= grants1 + 32'd1;
            if ((!granted && &req) || (ack && req[~cur])) conflicts <= conflicts + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench; expected completions are queued at drive time
// and popped whenever a dwait bit drops.
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    typedef struct {
        logic        id;
        logic [31:0] addr;
        logic        wen;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] dREN, dWEN, dwait;
    word_t      daddr0, daddr1, dstore0, dstore1, dload, ramaddr, ramstore, ramload;
    logic       ramREN, ramWEN;
    ramstate_t  ramstate;
    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;

    ram_arbiter dut (
        .CLK      (CLK),
        .RST      (RST),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr0   (daddr0),
        .daddr1   (daddr1),
        .dstore0  (dstore0),
        .dstore1  (dstore1),
        .dload    (dload),
        .dwait    (dwait),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        ramload = $urandom;
    endtask

    task automatic push(input logic id, input logic [31:0] addr, input logic wen);
        exp_t e;
        e.id = id;
        e.addr = addr;
        e.wen = wen;
        q.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (RST === 1'b0 && dwait !== 2'b11) begin
            check("sb_onehot", {31'd0, dwait === 2'b00}, 32'd0);
            if (q.size() == 0) begin
                check("sb_unexpected_ack", {30'd0, dwait}, 32'd3);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sb_id", {31'd0, dwait[0]}, {31'd0, e.id});
                check("sb_addr", ramaddr, e.addr);
                check("sb_wen", {31'd0, ramWEN}, {31'd0, e.wen});
                check("sb_dload", dload, ramload);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        dREN = '0; dWEN = '0;
        daddr0 = '0; daddr1 = '0; dstore0 = '0; dstore1 = '0;
        ramload = 32'h1111_0000;
        ramstate = FREE;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("rst_dwait", {30'd0, dwait}, 32'd3);
        check("rst_ren", {31'd0, ramREN}, 32'd0);
        check("rst_wen", {31'd0, ramWEN}, 32'd0);
        check("rst_addr", ramaddr, 32'd0);
        check("rst_store", ramstore, 32'd0);

        // Simultaneous reads after reset: core 0 first, then core 1 back-to-back.
        step();
        dREN = 2'b11; daddr0 = 32'h100; daddr1 = 32'h104; ramstate = ACCESS;
        push(1'b0, 32'h100, 1'b0);
        push(1'b1, 32'h104, 1'b0);
        @(negedge CLK);
        check("s1_idle_dwait", {30'd0, dwait}, 32'd3);
        check("s1_idle_ren", {31'd0, ramREN}, 32'd0);
        step();
        @(negedge CLK);
        check("s1_g0_addr", ramaddr, 32'h100);
        check("s1_g0_dwait", {30'd0, dwait}, 32'd2);
        step();
        dREN = 2'b10;
        @(negedge CLK);
        check("s1_g1_addr", ramaddr, 32'h104);
        check("s1_g1_dwait", {30'd0, dwait}, 32'd1);
        step();
        dREN = 2'b00;
        @(negedge CLK);
        check("s1_end_dwait", {30'd0, dwait}, 32'd3);

        // Core 1 write held through three BUSY cycles.
        step();
        dWEN = 2'b10; daddr1 = 32'h200; dstore1 = 32'hDEADBEEF; ramstate = BUSY;
        push(1'b1, 32'h200, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge CLK);
            check("s2_busy_wen", {31'd0, ramWEN}, 32'd1);
            check("s2_busy_addr", ramaddr, 32'h200);
            check("s2_busy_store", ramstore, 32'hDEADBEEF);
            check("s2_busy_dwait", {30'd0, dwait}, 32'd3);
        end
        step();
        ramstate = ACCESS;
        @(negedge CLK);
        check("s2_acc_dwait", {30'd0, dwait}, 32'd1);
        step();
        dWEN = 2'b00; ramstate = FREE;
        @(negedge CLK);
        check("s2_end_wen", {31'd0, ramWEN}, 32'd0);

        // Continuous contention: grants must alternate 0,1,0,1...
        step();
        dREN = 2'b01; dWEN = 2'b10; daddr0 = 32'h300; daddr1 = 32'h304; dstore1 = 32'h5A5A5A5A;
        ramstate = BUSY;
        for (int k = 0; k < 8; k++) push(k[0], k[0] ? 32'h304 : 32'h300, k[0]);
        for (int c = 1; c <= 16; c++) begin
            step();
            ramstate = c[0] ? BUSY : ACCESS;
            if (c == 15) dREN = 2'b00;
        end
        step();
        dWEN = 2'b00; ramstate = FREE;
        @(negedge CLK);
        check("s3_drained", q.size(), 32'd0);
        check("s3_end_ren", {31'd0, ramREN}, 32'd0);

        // Core 0 aborts while core 1 waits: core 1 takes over, no ack for core 0.
        step();
        dREN = 2'b01; daddr0 = 32'h400; ramstate = BUSY;
        step();
        dREN = 2'b11; daddr1 = 32'h404;
        push(1'b1, 32'h404, 1'b0);
        @(negedge CLK);
        check("s4_g0_addr", ramaddr, 32'h400);
        step();
        dREN = 2'b10;
        @(negedge CLK);
        check("s4_abort_dwait", {30'd0, dwait}, 32'd3);
        check("s4_abort_ren", {31'd0, ramREN}, 32'd0);
        step();
        ramstate = ACCESS;
        @(negedge CLK);
        check("s4_g1_addr", ramaddr, 32'h404);
        check("s4_g1_ren", {31'd0, ramREN}, 32'd1);
        step();
        dREN = 2'b00; ramstate = FREE;

        // Serve core 0, then let core 1 abort: the tie that follows must go to core 1.
        step();
        dREN = 2'b01; daddr0 = 32'h410; ramstate = ACCESS;
        push(1'b0, 32'h410, 1'b0);
        step();
        step();
        dREN = 2'b10; daddr1 = 32'h414; ramstate = BUSY;
        step();
        @(negedge CLK);
        check("s4b_g1_addr", ramaddr, 32'h414);
        step();
        dREN = 2'b00;
        @(negedge CLK);
        check("s4b_abort_dwait", {30'd0, dwait}, 32'd3);
        step();
        dREN = 2'b11; daddr0 = 32'h420; daddr1 = 32'h424; ramstate = ACCESS;
        push(1'b1, 32'h424, 1'b0);
        push(1'b0, 32'h420, 1'b0);
        step();
        @(negedge CLK);
        check("s4b_prio_addr", ramaddr, 32'h424);
        step();
        dREN = 2'b01;
        step();
        dREN = 2'b00; ramstate = FREE;

        // Reset in the middle of a BUSY grant drops strobes immediately.
        step();
        dREN = 2'b01; daddr0 = 32'h500; ramstate = BUSY;
        step();
        @(negedge CLK);
        check("s5_pre_ren", {31'd0, ramREN}, 32'd1);
        #1 RST = 1'b1;
        #1;
        check("s5_rst_ren", {31'd0, ramREN}, 32'd0);
        check("s5_rst_dwait", {30'd0, dwait}, 32'd3);
        check("s5_rst_addr", ramaddr, 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("s5_post_idle_ren", {31'd0, ramREN}, 32'd0);
        step();
        ramstate = ACCESS;
        push(1'b0, 32'h500, 1'b0);
        @(negedge CLK);
        check("s5_regrant_ren", {31'd0, ramREN}, 32'd1);
        step();
        dREN = 2'b00; ramstate = FREE;

        // ERROR acks like ACCESS and still hands off back-to-back.
        step();
        dREN = 2'b11; daddr0 = 32'h600; daddr1 = 32'h604; ramstate = ERROR;
        push(1'b1, 32'h604, 1'b0);
        push(1'b0, 32'h600, 1'b0);
        step();
        @(negedge CLK);
        check("s6_err_dwait", {30'd0, dwait}, 32'd1);
        check("s6_err_dload", dload, ramload);
        step();
        dREN = 2'b01;
        @(negedge CLK);
        check("s6_handoff_dwait", {30'd0, dwait}, 32'd2);
        step();
        dREN = 2'b00; ramstate = FREE;
        @(negedge CLK);
        check("s6_end_dwait", {30'd0, dwait}, 32'd3);

        repeat (2) step();
        check("sb_drain", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single `cpu_ram_if` RAM port between the two cores of the multicore processor: core 0 (PC0 side) and core 1 (PC1 side).
- Round-robin, one outstanding RAM transaction at a time, held until the RAM reports completion.
- Sits between the cores and the testbench-control mux in the system top, so testbench override remains downstream.

Parameters:
- NREQ, 2, number of requesters; only 2 supported, fixed-width ports.
- RESET_PRIO, 0, requester holding priority out of reset (0 or 1).

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous reset, active-high.
- dREN  in  2  per-requester read request, bit i = core i.
- dWEN  in  2  per-requester write request; REN and WEN both high from one requester is illegal.
- daddr0, daddr1  in  32  word address per requester (word_t).
- dstore0, dstore1  in  32  write data per requester.
- dload  out  32  read data, common to both requesters.
- dwait  out  2  bit i low = core i transaction completes this cycle.
- ramREN, ramWEN  out  1  RAM strobes.
- ramaddr, ramstore  out  32  RAM address and write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

Behaviour:
- req[i] = dREN[i] | dWEN[i].
- FSM states (arb_state_t): IDLE, GRANT0, GRANT1. Registered state plus 1-bit `last` (the requester last served).
- Reset (async, RST=1): state=IDLE, last=~RESET_PRIO. Outputs while in IDLE: ramREN=ramWEN=0, ramaddr=ramstore=0, dwait=2'b11, dload=ramload.
- IDLE transitions:
  - only req[0] -> GRANT0; only req[1] -> GRANT1.
  - both requesting -> grant ~last.
  - none -> stay in IDLE.
- Latency: a request sampled in IDLE at edge n is granted from cycle n+1. Minimum one cycle arbitration overhead.
- GRANTi outputs: ramREN/ramWEN/ramaddr/ramstore combinationally mirror requester i. The other requester's dwait bit is 1.
- Completion: in GRANTi with ramstate==ACCESS, dwait[i]=0 combinationally that cycle, and dload carries ramload. At the next edge:
  - last<=i.
  - if req[~i] -> GRANT~i (back-to-back, no IDLE bubble).
  - else -> IDLE.
- ERROR is treated exactly as ACCESS: the transaction is acked. Error reporting is the cores' responsibility.
- ramstate FREE/BUSY: hold the grant; dwait[i]=1.
- Requester i drops req mid-grant (no ACCESS yet): abort. Next state chosen as from IDLE, excluding i; last is unchanged; no ack is issued.
- No preemption: a granted requester keeps the port until ACCESS/ERROR or it drops its request.
- Fairness: with both requesting continuously, grants strictly alternate 0,1,0,1.
- Reset mid-transaction: state returns to IDLE immediately (async), and strobes drop in the same cycle.
- dload is always a passthrough of ramload; consumers qualify it with dwait.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined: adds outputs grants0, grants1 (32 each) and conflicts (32).
  - grants counters increment on each completion cycle for that requester.
  - conflicts increments on each cycle where both req bits are high and state==IDLE, or on a back-to-back handoff.
  - All counters wrap modulo 2^32 and reset to 0.
- Undefined: no counter logic and no extra ports.

Decomposition:
- cpu_types_pkg gains: arb_state_t enum (IDLE, GRANT0, GRANT1); constant ARB_NREQ=2.
- ramstate_t and word_t come from cpu_types_pkg.
- One natural sub-module: rr_pick2, a combinational 2-way round-robin chooser (inputs req[1:0], last, exclude mask; outputs valid and winner). It is reused for the IDLE choice and the abort/handoff choice.

Test Plan:
- Reset with RESET_PRIO=0, both cores request read in the same cycle -> GRANT0 first: ramaddr=daddr0 from cycle 1, dwait=2'b10 on ACCESS, then GRANT1 next cycle with no IDLE.
- Core1 alone writes addr 0x200, data 0xDEADBEEF, RAM returns BUSY for 3 cycles then ACCESS -> ramWEN=1 and ramaddr=0x200 held 4 cycles, dwait[1]=0 only on the ACCESS cycle, dwait[0]=1 throughout.
- Both cores request continuously for 8 transactions, ACCESS 1 cycle after each grant -> grant order 0,1,0,1,0,1,0,1; with ARB_STATS_EN, grants0=grants1=4.
- Core0 granted, drops dREN before ACCESS while core1 requests -> next cycle GRANT1, no dwait[0] low, last unchanged (still reflects prior serve).
- Assert RST mid-GRANT0 during BUSY -> ramREN=0 and dwait=2'b11 in the same cycle; after release, the first single request is granted one cycle later.
- ramstate=ERROR during GRANT1 read -> dwait[1]=0 that cycle, dload=ramload, FSM advances as on ACCESS.
